// File: rtl/spi_controller.sv
// SPI mode-0 initiator, one 16-bit {rw,addr,data} frame per request; first SCLK edge D cycles after accept, done at cycle 34*CLK_DIV+1.
// Backpressure: req_ready low from accept until done; SPI_READBACK_EN adds cipo capture into rd_data for read frames.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done
`ifdef SPI_READBACK_EN
  ,
  input  logic       cipo,
  output logic [7:0] rd_data
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  hcnt;
  logic [3:0]  bitcnt;
  logic [15:0] shreg;

`ifdef SPI_READBACK_EN
  logic       rw_q;
  logic [7:0] rx_sr;
`endif

  // copi is the shift register MSB; clearing the register on GAP entry drives copi low.
  assign copi = shreg[15];
  assign busy = ~req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      hcnt      <= 8'd0;
      bitcnt    <= 4'd0;
      shreg     <= 16'd0;
`ifdef SPI_READBACK_EN
      rw_q      <= 1'b0;
      rx_sr     <= 8'd0;
      rd_data   <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= SHIFT;
            req_ready <= 1'b0;
            ncs       <= 1'b0;
            sclk      <= 1'b0;
            shreg     <= {req_rw, req_addr, req_data};
            hcnt      <= RELOAD;
            bitcnt    <= 4'd0;
`ifdef SPI_READBACK_EN
            rw_q      <= req_rw;
`endif
          end
        end

        SHIFT: begin
          if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
          end else begin
            hcnt <= RELOAD;
            if (!sclk) begin
              sclk <= 1'b1;
`ifdef SPI_READBACK_EN
              // Data phase is the last eight bits of the frame.
              if (bitcnt[3])
                rx_sr <= {rx_sr[6:0], cipo};
`endif
            end else begin
              sclk <= 1'b0;
              if (bitcnt == 4'd15) begin
                state <= HOLD;
              end else begin
                bitcnt <= bitcnt + 4'd1;
                shreg  <= {shreg[14:0], 1'b0};
              end
            end
          end
        end

        HOLD: begin
          if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
          end else begin
            hcnt  <= RELOAD;
            state <= GAP;
            ncs   <= 1'b1;
            shreg <= 16'd0;
          end
        end

        GAP: begin
          if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
            done      <= 1'b1;
            hcnt      <= 8'd0;
            bitcnt    <= 4'd0;
`ifdef SPI_READBACK_EN
            if (!rw_q)
              rd_data <= rx_sr;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: scoreboard of expected frames plus a behavioural SPI register peripheral on the pins.
module tb_spi_controller;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready, sclk, copi, ncs, busy, done;
`ifdef SPI_READBACK_EN
  logic       cipo = 1'b0;
  logic [7:0] rd_data;
  logic [7:0] cipo_val = 8'h00;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  regs[0:127];

  logic        prev_sclk = 1'b0;
  logic        prev_ncs  = 1'b1;
  logic [15:0] mon_bits  = 16'h0;
  logic [15:0] sb_exp;
  int          mon_n     = 0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .busy      (busy),
    .done      (done)
`ifdef SPI_READBACK_EN
    ,
    .cipo      (cipo),
    .rd_data   (rd_data)
`endif
  );

  // Peripheral model: samples copi on sclk rising edges, commits a write when ncs rises.
  always @(negedge clk) begin
    if (rst) begin
      mon_n = 0;
    end else begin
      if (!ncs && sclk && !prev_sclk) begin
        mon_bits = {mon_bits[14:0], copi};
        mon_n++;
      end
      if (ncs && !prev_ncs && mon_n == 16) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_frame: got %h, no frame expected", mon_bits);
        end else begin
          sb_exp = exp_q.pop_front();
          if (mon_bits !== sb_exp) begin
            errors++;
            $display("FAIL sb_frame: got %h want %h", mon_bits, sb_exp);
          end
        end
        if (mon_bits[15])
          regs[mon_bits[14:8]] = mon_bits[7:0];
      end
      if (ncs && !prev_ncs)
        mon_n = 0;
    end
    prev_sclk = sclk;
    prev_ncs  = ncs;
`ifdef SPI_READBACK_EN
    cipo = (mon_n >= 8 && mon_n < 16) ? cipo_val[3'(15 - mon_n)] : 1'b0;
`endif
  end

  // Called at a negedge with req_ready high; returns at the negedge of cycle 1.
  task automatic start_req(input logic rw, input logic [6:0] a, input logic [7:0] d);
    req_rw    = rw;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    exp_q.push_back({rw, a, d});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 7'h0; req_data = 8'h0;
    repeat (3) @(negedge clk);
    checks++; if (ncs !== 1'b1)       begin errors++; $display("FAIL reset_ncs: got %b want 1", ncs); end
    checks++; if (sclk !== 1'b0)      begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (copi !== 1'b0)      begin errors++; $display("FAIL reset_copi: got %b want 0", copi); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef SPI_READBACK_EN
    checks++; if (rd_data !== 8'h00)  begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int rises, bad, ncs_hi, done_at, done_cnt;
    logic ps, rdy_at_done;
    logic [15:0] bits;
    rises = 0; bad = 0; ncs_hi = -1; done_at = -1; done_cnt = 0;
    rdy_at_done = 1'b0; bits = 16'h0;
    start_req(1'b1, 7'h04, 8'h80);
    checks++; if (ncs !== 1'b0)  begin errors++; $display("FAIL sw_ncs_c1: got %b want 0", ncs); end
    checks++; if (copi !== 1'b1) begin errors++; $display("FAIL sw_copi_c1: got %b want 1", copi); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy_c1: got %b want 1", busy); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL sw_sclk_c1: got %b want 0", sclk); end
    ps = sclk;
    for (int n = 2; n <= 36 * D; n++) begin
      @(negedge clk);
      if (sclk && !ps) begin
        if (n != 2 * D * rises + D + 1) bad++;
        bits = {bits[14:0], copi};
        rises++;
      end
      ps = sclk;
      if (ncs && ncs_hi < 0) ncs_hi = n;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = n; rdy_at_done = req_ready; end
      end
    end
    checks++; if (rises != 16)          begin errors++; $display("FAIL sw_rises: got %0d want 16", rises); end
    checks++; if (bad != 0)             begin errors++; $display("FAIL sw_rise_pos: got %0d misplaced want 0", bad); end
    checks++; if (bits !== 16'h8480)    begin errors++; $display("FAIL sw_bits: got %h want 8480", bits); end
    checks++; if (ncs_hi != 33 * D + 1) begin errors++; $display("FAIL sw_ncs_rise: got %0d want %0d", ncs_hi, 33 * D + 1); end
    checks++; if (done_at != 34 * D + 1) begin errors++; $display("FAIL sw_done_at: got %0d want %0d", done_at, 34 * D + 1); end
    checks++; if (done_cnt != 1)        begin errors++; $display("FAIL sw_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (rdy_at_done !== 1'b1) begin errors++; $display("FAIL sw_ready_at_done: got %b want 1", rdy_at_done); end
  endtask

  task automatic test_back_to_back;
    int hi, n;
    bit ok;
    hi = 0; n = 0; ok = 1'b0;
    start_req(1'b1, 7'h00, 8'hA5);
    while (!ok && n < 40 * D) begin
      @(negedge clk);
      n++;
      if (ncs) hi++;
      if (done) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done1: got timeout want done"); end
    start_req(1'b1, 7'h03, 8'h3C);
    // GAP cycles plus the done cycle on which the next request is taken.
    checks++; if (hi != D + 1)   begin errors++; $display("FAIL b2b_ncs_high: got %0d want %0d", hi, D + 1); end
    checks++; if (ncs !== 1'b0)  begin errors++; $display("FAIL b2b_ncs_c1: got %b want 0", ncs); end
    wait_done(40 * D, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done2: got timeout want done"); end
    checks++; if (regs[0] !== 8'hA5) begin errors++; $display("FAIL b2b_reg0: got %h want a5", regs[0]); end
    checks++; if (regs[3] !== 8'h3C) begin errors++; $display("FAIL b2b_reg3: got %h want 3c", regs[3]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_sb_empty: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_ignored_request;
    int early, n;
    bit ok;
    early = 0; n = 0; ok = 1'b0;
    start_req(1'b1, 7'h11, 8'h22);
    repeat (10) @(negedge clk);
    req_rw = 1'b1; req_addr = 7'h7F; req_data = 8'h55; req_valid = 1'b1;
    exp_q.push_back({1'b1, 7'h7F, 8'h55});
    while (!ok && n < 40 * D) begin
      @(negedge clk);
      n++;
      if (done) ok = 1'b1;
      else if (req_ready) early++;
    end
    checks++; if (!ok)                begin errors++; $display("FAIL ign_done: got timeout want done"); end
    checks++; if (early != 0)         begin errors++; $display("FAIL ign_ready_early: got %0d want 0", early); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ign_ready_done: got %b want 1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (ncs !== 1'b0) begin errors++; $display("FAIL ign_accept: got ncs %b want 0", ncs); end
    wait_done(40 * D, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_done2: got timeout want done"); end
    checks++; if (regs[7'h7F] !== 8'h55) begin errors++; $display("FAIL ign_reg7f: got %h want 55", regs[7'h7F]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ign_sb_empty: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int dcnt;
    bit ok;
    dcnt = 0;
    start_req(1'b1, 7'h12, 8'h34);
    void'(exp_q.pop_back());
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ncs !== 1'b1)       begin errors++; $display("FAIL rmid_ncs: got %b want 1", ncs); end
    checks++; if (sclk !== 1'b0)      begin errors++; $display("FAIL rmid_sclk: got %b want 0", sclk); end
    checks++; if (copi !== 1'b0)      begin errors++; $display("FAIL rmid_copi: got %b want 0", copi); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    rst = 1'b0;
    for (int i = 0; i < 4 * D; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses want 0", dcnt); end
    start_req(1'b1, 7'h01, 8'hFF);
    wait_done(40 * D, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_done: got timeout want done"); end
    checks++; if (regs[1] !== 8'hFF)  begin errors++; $display("FAIL rmid_reg1: got %h want ff", regs[1]); end
    checks++; if (regs[7'h12] !== 8'h00) begin errors++; $display("FAIL rmid_reg12: got %h want 00", regs[7'h12]); end
  endtask

`ifdef SPI_READBACK_EN
  task automatic test_readback;
    bit ok;
    cipo_val = 8'h5A;
    start_req(1'b0, 7'h02, 8'h00);
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rb_initial: got %h want 00", rd_data); end
    wait_done(40 * D, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rb_done: got timeout want done"); end
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL rb_read: got %h want 5a", rd_data); end
    cipo_val = 8'hC3;
    start_req(1'b1, 7'h02, 8'h11);
    wait_done(40 * D, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rb_done2: got timeout want done"); end
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL rb_hold: got %h want 5a", rd_data); end
    checks++; if (regs[2] !== 8'h11) begin errors++; $display("FAIL rb_reg2: got %h want 11", regs[2]); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    test_reset;
    test_single_write;
    test_back_to_back;
    test_ignored_request;
    test_reset_mid;
`ifdef SPI_READBACK_EN
    test_readback;
`endif
    repeat (4) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_sb_empty: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
